// File: rtl/alu_rs_aged_if.sv
// Dispatch, CDB snoop and result handshake bundle for the aged ALU reservation station.
// master drives dispatch/CDB/res_ready; slave is the station itself.
interface alu_rs_aged_if #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 4,
  parameter int NUM_CDB = 2
);
  logic                       rdy;
  logic                       flush;
  logic                       disp_valid;
  logic [3:0]                 disp_op;
  logic [TAG_W-1:0]           disp_rob;
  logic                       disp_s1_rdy;
  logic [XLEN-1:0]            disp_s1;
  logic                       disp_s2_rdy;
  logic [XLEN-1:0]            disp_s2;
  logic                       disp_use_imm;
  logic [XLEN-1:0]            disp_imm;
  logic [NUM_CDB-1:0]         cdb_valid;
  logic [NUM_CDB*TAG_W-1:0]   cdb_tag;
  logic [NUM_CDB*XLEN-1:0]    cdb_val;
  logic                       full;
  logic                       res_valid;
  logic                       res_ready;
  logic [TAG_W-1:0]           res_rob;
  logic [XLEN-1:0]            res_val;

  modport master (
    output rdy, flush, disp_valid, disp_op, disp_rob, disp_s1_rdy, disp_s1,
           disp_s2_rdy, disp_s2, disp_use_imm, disp_imm,
           cdb_valid, cdb_tag, cdb_val, res_ready,
    input  full, res_valid, res_rob, res_val
  );

  modport slave (
    input  rdy, flush, disp_valid, disp_op, disp_rob, disp_s1_rdy, disp_s1,
           disp_s2_rdy, disp_s2, disp_use_imm, disp_imm,
           cdb_valid, cdb_tag, cdb_val, res_ready,
    output full, res_valid, res_rob, res_val
  );
endinterface

// File: rtl/alu_rs_aged.sv
// ALU reservation station: CDB wakeup, oldest-ready select, one registered ALU result (2 cycles dispatch->result).
// Result register holds while res_ready is low; nothing issues until it drains.
module alu_rs_aged #(
  parameter int DEPTH   = 16,
  parameter int XLEN    = 32,
  parameter int TAG_W   = 4,
  parameter int NUM_CDB = 2
) (
  input  logic          clk,
  input  logic          rst,
  alu_rs_aged_if.slave  bus
);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SHW = $clog2(XLEN);

  typedef struct packed {
    logic [3:0]       op;
    logic [TAG_W-1:0] rob;
    logic             s1_rdy;
    logic [XLEN-1:0]  s1;
    logic             s2_rdy;
    logic [XLEN-1:0]  s2;
  } ent_t;

  ent_t             r_ent   [DEPTH];
  logic [DEPTH-1:0] r_busy;
  // r_older[i][j] set means entry j was dispatched before entry i
  logic [DEPTH-1:0] r_older [DEPTH];
  logic             r_res_valid;
  logic [TAG_W-1:0] r_res_rob;
  logic [XLEN-1:0]  r_res_val;

  logic [TAG_W-1:0] w_cdb_tag [NUM_CDB];
  logic [XLEN-1:0]  w_cdb_val [NUM_CDB];
  ent_t             w_de;
  ent_t             w_wk    [DEPTH];
  logic [DEPTH-1:0] w_cand;
  logic [DEPTH-1:0] w_gnt;
  logic [IW-1:0]    w_gnt_idx;
  logic [IW-1:0]    w_free_idx;
  logic             w_full;
  logic             w_disp;
  logic             w_issue;
  logic [3:0]       w_op;
  logic [XLEN-1:0]  w_a;
  logic [XLEN-1:0]  w_b;
  logic [SHW-1:0]   w_shamt;
  logic [XLEN-1:0]  w_alu;

  always_comb begin
    for (int c = 0; c < NUM_CDB; c++) begin
      w_cdb_tag[c] = bus.cdb_tag[c*TAG_W +: TAG_W];
      w_cdb_val[c] = bus.cdb_val[c*XLEN +: XLEN];
    end
  end

  // Snoop loops run high->low so the lowest matching channel is written last and wins.
  always_comb begin
    w_de.op     = bus.disp_op;
    w_de.rob    = bus.disp_rob;
    w_de.s1_rdy = bus.disp_s1_rdy;
    w_de.s1     = bus.disp_s1;
    w_de.s2_rdy = bus.disp_s2_rdy | bus.disp_use_imm;
    w_de.s2     = bus.disp_use_imm ? bus.disp_imm : bus.disp_s2;
    for (int c = NUM_CDB-1; c >= 0; c--) begin
      if (bus.cdb_valid[c] && !bus.disp_s1_rdy &&
          bus.disp_s1[TAG_W-1:0] == w_cdb_tag[c]) begin
        w_de.s1_rdy = 1'b1;
        w_de.s1     = w_cdb_val[c];
      end
      if (bus.cdb_valid[c] && !(bus.disp_s2_rdy | bus.disp_use_imm) &&
          bus.disp_s2[TAG_W-1:0] == w_cdb_tag[c]) begin
        w_de.s2_rdy = 1'b1;
        w_de.s2     = w_cdb_val[c];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_wk[i] = r_ent[i];
      for (int c = NUM_CDB-1; c >= 0; c--) begin
        if (bus.cdb_valid[c] && !r_ent[i].s1_rdy &&
            r_ent[i].s1[TAG_W-1:0] == w_cdb_tag[c]) begin
          w_wk[i].s1_rdy = 1'b1;
          w_wk[i].s1     = w_cdb_val[c];
        end
        if (bus.cdb_valid[c] && !r_ent[i].s2_rdy &&
            r_ent[i].s2[TAG_W-1:0] == w_cdb_tag[c]) begin
          w_wk[i].s2_rdy = 1'b1;
          w_wk[i].s2     = w_cdb_val[c];
        end
      end
    end
  end

  always_comb begin
    w_gnt_idx  = '0;
    w_free_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_cand[i] = r_busy[i] & r_ent[i].s1_rdy & r_ent[i].s2_rdy;
    end
    for (int i = 0; i < DEPTH; i++) begin
      w_gnt[i] = w_cand[i] & ~(|(w_cand & r_older[i]));
      if (w_gnt[i]) w_gnt_idx = IW'(i);
    end
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!r_busy[i]) w_free_idx = IW'(i);
    end
    w_full  = &r_busy;
    w_disp  = bus.disp_valid & ~w_full;
    w_issue = (|w_cand) & (~r_res_valid | bus.res_ready);
  end

  always_comb begin
    w_op    = r_ent[w_gnt_idx].op;
    w_a     = r_ent[w_gnt_idx].s1;
    w_b     = r_ent[w_gnt_idx].s2;
    w_shamt = w_b[SHW-1:0];
    case (w_op)
      4'd0:    w_alu = w_a + w_b;
      4'd1:    w_alu = w_a - w_b;
      4'd2:    w_alu = w_a ^ w_b;
      4'd3:    w_alu = w_a | w_b;
      4'd4:    w_alu = w_a & w_b;
      4'd5:    w_alu = w_a << w_shamt;
      4'd6:    w_alu = w_a >> w_shamt;
      4'd7:    w_alu = $unsigned($signed(w_a) >>> w_shamt);
      4'd8:    w_alu = XLEN'($signed(w_a) < $signed(w_b));
      4'd9:    w_alu = XLEN'(w_a < w_b);
      4'd10:   w_alu = XLEN'(w_a == w_b);
      4'd11:   w_alu = XLEN'(w_a != w_b);
      4'd12:   w_alu = XLEN'($signed(w_a) >= $signed(w_b));
      4'd13:   w_alu = XLEN'(w_a >= w_b);
      4'd14:   w_alu = (w_a + w_b) & ~XLEN'(1);
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy      <= '0;
      r_res_valid <= 1'b0;
      r_res_rob   <= '0;
      r_res_val   <= '0;
      for (int i = 0; i < DEPTH; i++) r_older[i] <= '0;
    end else if (bus.rdy) begin
      if (bus.flush) begin
        r_busy      <= '0;
        r_res_valid <= 1'b0;
        r_res_rob   <= '0;
        r_res_val   <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (w_issue && w_gnt[i]) begin
            r_busy[i] <= 1'b0;
          end else if (w_disp && w_free_idx == IW'(i)) begin
            r_busy[i] <= 1'b1;
            r_ent[i]  <= w_de;
          end else begin
            r_ent[i]  <= w_wk[i];
          end
        end
        // New entry is younger than every live entry; clear its column so stale bits from a previous occupant vanish.
        if (w_disp) begin
          r_older[w_free_idx] <= r_busy;
          for (int i = 0; i < DEPTH; i++) begin
            if (IW'(i) != w_free_idx) r_older[i][w_free_idx] <= 1'b0;
          end
        end
        if (w_issue) begin
          r_res_valid <= 1'b1;
          r_res_rob   <= r_ent[w_gnt_idx].rob;
          r_res_val   <= w_alu;
        end else if (bus.res_ready) begin
          r_res_valid <= 1'b0;
        end
      end
    end
  end

  assign bus.full      = w_full;
  assign bus.res_valid = r_res_valid;
  assign bus.res_rob   = r_res_rob;
  assign bus.res_val   = r_res_val;
endmodule

// File: tb/tb_alu_rs_aged.sv
// Directed bench for alu_rs_aged: ALU op table, wakeup/bypass, age order with slot reuse, backpressure, flush, rdy stall.
module tb_alu_rs_aged;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_rs_aged_if #(.XLEN(32), .TAG_W(4), .NUM_CDB(2)) bus ();

  alu_rs_aged #(.DEPTH(16), .XLEN(32), .TAG_W(4), .NUM_CDB(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        imm;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [3:0] op, input logic [3:0] rob,
                      input logic s1r, input logic [31:0] s1,
                      input logic s2r, input logic [31:0] s2,
                      input logic ui, input logic [31:0] imm);
    bus.disp_valid   = 1'b1;
    bus.disp_op      = op;
    bus.disp_rob     = rob;
    bus.disp_s1_rdy  = s1r;
    bus.disp_s1      = s1;
    bus.disp_s2_rdy  = s2r;
    bus.disp_s2      = s2;
    bus.disp_use_imm = ui;
    bus.disp_imm     = imm;
  endtask

  task automatic nodisp();
    bus.disp_valid = 1'b0;
  endtask

  task automatic cdb(input int ch, input logic [3:0] tag, input logic [31:0] val);
    bus.cdb_valid[ch]        = 1'b1;
    bus.cdb_tag[ch*4 +: 4]   = tag;
    bus.cdb_val[ch*32 +: 32] = val;
  endtask

  task automatic nocdb();
    bus.cdb_valid = '0;
  endtask

  task automatic chk_res(input string name, input logic v, input logic [3:0] rob, input logic [31:0] val);
    chk({name, "_valid"}, 32'(bus.res_valid), 32'(v));
    chk({name, "_rob"}, 32'(bus.res_rob), 32'(rob));
    chk({name, "_val"}, bus.res_val, val);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{4'd0,  32'h0000_0005, 32'h0000_0007, 1'b0, 32'h0000_000C};
    vecs[1]  = '{4'd1,  32'h0000_000A, 32'h0000_0004, 1'b0, 32'h0000_0006};
    vecs[2]  = '{4'd2,  32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0, 32'hFF00_0FF0};
    vecs[3]  = '{4'd3,  32'h1200_0034, 32'h0034_1200, 1'b0, 32'h1234_1234};
    vecs[4]  = '{4'd4,  32'hFFFF_0000, 32'h0F0F_0F0F, 1'b0, 32'h0F0F_0000};
    vecs[5]  = '{4'd5,  32'h0000_0001, 32'h0000_0023, 1'b0, 32'h0000_0008};
    vecs[6]  = '{4'd6,  32'h8000_0000, 32'h0000_0004, 1'b0, 32'h0800_0000};
    vecs[7]  = '{4'd7,  32'h8000_0000, 32'h0000_0004, 1'b0, 32'hF800_0000};
    vecs[8]  = '{4'd8,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0001};
    vecs[9]  = '{4'd9,  32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001};
    vecs[10] = '{4'd9,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000};
    vecs[11] = '{4'd10, 32'h0000_0005, 32'h0000_0005, 1'b0, 32'h0000_0001};
    vecs[12] = '{4'd11, 32'h0000_0005, 32'h0000_0005, 1'b0, 32'h0000_0000};
    vecs[13] = '{4'd12, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001};
    vecs[14] = '{4'd13, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000};
    vecs[15] = '{4'd14, 32'h0000_1001, 32'h0000_0002, 1'b1, 32'h0000_1002};
    vecs[16] = '{4'd15, 32'h0000_0003, 32'h0000_0004, 1'b0, 32'h0000_0000};
    vecs[17] = '{4'd7,  32'h7000_0000, 32'h0000_0024, 1'b0, 32'h0700_0000};

    rst = 1'b1;
    bus.rdy = 1'b1;
    bus.flush = 1'b0;
    bus.res_ready = 1'b1;
    disp(4'd0, 4'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    nodisp();
    bus.cdb_valid = '0;
    bus.cdb_tag = '0;
    bus.cdb_val = '0;
    step();
    step();
    rst = 1'b0;
    chk("reset_full", 32'(bus.full), 32'd0);
    chk_res("reset", 1'b0, 4'd0, 32'd0);

    // Basic ADD, 2-cycle latency and drain
    disp(4'd0, 4'd3, 1'b1, 32'd5, 1'b1, 32'd7, 1'b0, 32'd0);
    step();
    nodisp();
    chk("add_full", 32'(bus.full), 32'd0);
    chk("add_lat1_valid", 32'(bus.res_valid), 32'd0);
    step();
    chk_res("add", 1'b1, 4'd3, 32'd12);
    step();
    chk("add_drain_valid", 32'(bus.res_valid), 32'd0);

    // ALU op table; use_imm vectors leave s2 not-ready with a junk tag
    for (int i = 0; i < 18; i++) begin
      disp(vecs[i].op, 4'(i), 1'b1, vecs[i].a, !vecs[i].imm,
           vecs[i].imm ? 32'h0000_DEAD : vecs[i].b, vecs[i].imm, vecs[i].b);
      step();
      nodisp();
      step();
      chk_res($sformatf("vec%0d", i), 1'b1, 4'(i), vecs[i].exp);
      step();
      chk($sformatf("vec%0d_drain", i), 32'(bus.res_valid), 32'd0);
    end

    // Wakeup from CDB, lowest channel wins on duplicate tag
    disp(4'd1, 4'd1, 1'b0, 32'd9, 1'b1, 32'd4, 1'b0, 32'd0);
    step();
    nodisp();
    step();
    chk("wait_valid", 32'(bus.res_valid), 32'd0);
    cdb(0, 4'd9, 32'd10);
    cdb(1, 4'd9, 32'd50);
    step();
    nocdb();
    chk("woken_valid", 32'(bus.res_valid), 32'd0);
    step();
    chk_res("wake", 1'b1, 4'd1, 32'd6);
    step();

    // Same-cycle bypass at dispatch
    disp(4'd1, 4'd2, 1'b0, 32'd9, 1'b1, 32'd4, 1'b0, 32'd0);
    cdb(0, 4'd9, 32'd10);
    cdb(1, 4'd9, 32'd99);
    step();
    nodisp();
    nocdb();
    step();
    chk_res("bypass", 1'b1, 4'd2, 32'd6);
    step();

    // Fragment slots 0 and 2, keep Y (rob 0) in slot 1 as oldest
    disp(4'd0, 4'd14, 1'b0, 32'd12, 1'b1, 32'd1, 1'b0, 32'd0);
    step();
    disp(4'd0, 4'd0, 1'b0, 32'd15, 1'b1, 32'd0, 1'b0, 32'd0);
    step();
    disp(4'd0, 4'd13, 1'b0, 32'd12, 1'b1, 32'd2, 1'b0, 32'd0);
    step();
    nodisp();
    cdb(0, 4'd12, 32'd20);
    step();
    nocdb();
    step();
    chk_res("fragX", 1'b1, 4'd14, 32'd21);
    step();
    chk_res("fragZ", 1'b1, 4'd13, 32'd22);
    step();
    chk("frag_drain_valid", 32'(bus.res_valid), 32'd0);
    for (int k = 1; k < 16; k++) begin
      disp(4'd0, 4'(k), 1'b0, 32'd15, 1'b1, 32'(k), 1'b0, 32'd0);
      step();
      if (k == 14) chk("fill15_full", 32'(bus.full), 32'd0);
    end
    nodisp();
    chk("fill16_full", 32'(bus.full), 32'd1);
    disp(4'd0, 4'd9, 1'b1, 32'd1, 1'b1, 32'd1, 1'b0, 32'd0);
    step();
    nodisp();
    chk("extra_full", 32'(bus.full), 32'd1);
    chk("extra_valid", 32'(bus.res_valid), 32'd0);
    cdb(1, 4'd15, 32'd100);
    step();
    nocdb();
    for (int r = 0; r < 16; r++) begin
      step();
      chk_res($sformatf("age%0d", r), 1'b1, 4'(r), 32'd100 + 32'(r));
      if (r == 0) chk("age_full_after_issue", 32'(bus.full), 32'd0);
    end
    step();
    chk("age_drain_valid", 32'(bus.res_valid), 32'd0);

    // Backpressure: result holds, others wait, then drain in age order
    bus.res_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      disp(4'd0, 4'(k), 1'b1, 32'(k), 1'b1, 32'd0, 1'b0, 32'd0);
      step();
    end
    nodisp();
    for (int c = 0; c < 5; c++) begin
      chk_res($sformatf("hold%0d", c), 1'b1, 4'd1, 32'd1);
      step();
    end
    bus.res_ready = 1'b1;
    step();
    chk_res("release2", 1'b1, 4'd2, 32'd2);
    step();
    chk_res("release3", 1'b1, 4'd3, 32'd3);
    step();
    chk("release_drain_valid", 32'(bus.res_valid), 32'd0);

    // Flush beats a concurrent dispatch and kills the pending result
    bus.res_ready = 1'b0;
    for (int k = 4; k <= 8; k++) begin
      disp(4'd0, 4'(k), 1'b1, 32'(k), 1'b1, 32'd1, 1'b0, 32'd0);
      step();
    end
    chk_res("preflush", 1'b1, 4'd4, 32'd5);
    disp(4'd0, 4'd10, 1'b1, 32'd1, 1'b1, 32'd1, 1'b0, 32'd0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    nodisp();
    chk("flush_full", 32'(bus.full), 32'd0);
    chk_res("flush", 1'b0, 4'd0, 32'd0);
    bus.res_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      chk($sformatf("postflush%0d_valid", c), 32'(bus.res_valid), 32'd0);
    end

    // rdy low freezes everything, including dispatch and result drain
    bus.res_ready = 1'b0;
    disp(4'd0, 4'd5, 1'b1, 32'd1, 1'b1, 32'd1, 1'b0, 32'd0);
    step();
    disp(4'd0, 4'd6, 1'b1, 32'd2, 1'b1, 32'd2, 1'b0, 32'd0);
    step();
    nodisp();
    step();
    chk_res("prestall", 1'b1, 4'd5, 32'd2);
    bus.rdy = 1'b0;
    bus.res_ready = 1'b1;
    disp(4'd0, 4'd7, 1'b1, 32'd3, 1'b1, 32'd3, 1'b0, 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk_res($sformatf("stall%0d", c), 1'b1, 4'd5, 32'd2);
    end
    nodisp();
    bus.rdy = 1'b1;
    step();
    chk_res("unstall", 1'b1, 4'd6, 32'd4);
    step();
    chk("unstall_drain_valid", 32'(bus.res_valid), 32'd0);
    step();
    chk("unstall_idle_valid", 32'(bus.res_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_rs_aged.md
Name: alu_rs_aged

Overview:
- Parametrised ALU reservation station for the out-of-order core.
- Sits between the decoder/dispatch stage and the common data bus (CDB).
- Holds DEPTH waiting ALU/branch/JALR ops and snoops NUM_CDB result broadcast channels for operand wakeup.
- Issues the oldest ready entry (by dispatch order) into a registered ALU stage with valid/ready backpressure toward the CDB arbiter.

Parameters:
DEPTH, 16, number of entries (power of two, 2..32)
XLEN, 32, operand/result width
TAG_W, 4, ROB tag width
NUM_CDB, 2, number of broadcast channels snooped

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; when low, all state frozen
flush  in  1  mispredict flush; clears station and result register
disp_valid  in  1  dispatch request this cycle
disp_op  in  4  ALU op (encoding below)
disp_rob  in  TAG_W  destination ROB tag
disp_s1_rdy  in  1  source 1 value valid; if 0, disp_s1[TAG_W-1:0] is producer tag
disp_s1  in  XLEN  source 1 value or tag
disp_s2_rdy  in  1  same for source 2
disp_s2  in  XLEN  source 2 value or tag
disp_use_imm  in  1  source 2 replaced by disp_imm, treated ready
disp_imm  in  XLEN  immediate
cdb_valid  in  NUM_CDB  per-channel broadcast valid
cdb_tag  in  NUM_CDB*TAG_W  packed tags, channel 0 in LSBs
cdb_val  in  NUM_CDB*XLEN  packed values
full  out  1  no free entry
res_valid  out  1  result register valid
res_ready  in  1  consumer accepts result
res_rob  out  TAG_W  result ROB tag
res_val  out  XLEN  result value

Behaviour:
- Op encoding: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 EQ, 11 NE, 12 GE (signed), 13 GEU, 14 JALR = (a+b)&~1, 15 → 0.
- Shifts use b[log2(XLEN)-1:0]. Comparison ops return 0 or 1, zero-extended.
- Reset or flush (when rdy=1 or rst=1): all entries invalid, res_valid=0, res_rob=0, res_val=0, full=0. rst acts regardless of rdy. Flush has priority over dispatch, wakeup and issue in the same cycle.
- rdy=0 (no rst): no state changes; outputs hold.
- full is combinational from current occupancy: 1 iff all DEPTH entries busy.
- Dispatch:
  - Accepted iff disp_valid && !full; lowest-index free entry is written.
  - disp_valid while full is ignored (dispatcher error; no corruption).
  - Same-cycle bypass: a non-ready source whose tag matches any valid CDB channel is captured as ready with that channel's value. If channels match the same tag, the lowest channel wins.
- Wakeup: each busy entry's non-ready source matching a valid CDB tag becomes ready with that value next cycle, lowest channel winning.
- Age: strict dispatch order is tracked (age matrix or equivalent). An entry dispatched earlier is always older, independent of slot index.
- Select/issue:
  - Candidate = busy entry with both sources ready at cycle start; the oldest candidate is chosen.
  - Issue occurs iff a candidate exists and (!res_valid || res_ready).
  - On issue, the entry frees at the clock edge, and res_valid/res_rob/res_val load the ALU result at the same edge.
  - If res_valid && res_ready and no candidate, res_valid clears.
  - If res_valid && !res_ready, the result holds stable and nothing issues.
- Freed entries are reusable from the next cycle; a dispatch never targets the entry being issued that cycle.
- Latency: dispatch with both sources ready at edge N → candidate in cycle N+1 → res_valid at edge N+2 (with no older competitor and no backpressure).
- A source woken at edge N is issuable in cycle N+1. Wakeup values arriving in the issue cycle are not used by the issuing entry (already ready).
- Throughput: one issue per cycle.

Test Plan:
- Reset, then dispatch ADD (s1=5, s2=7, both ready, rob=3) → full=0; two cycles later res_valid=1, res_rob=3, res_val=12; res_ready=1 → res_valid=0 next cycle.
- Dispatch SUB rob=1 with s1 waiting tag 9, s2=4 ready. Two cycles later, cdb0 valid tag 9 val 10 → res_val=6, rob=1 two edges after the broadcast. Repeat with the broadcast in the dispatch cycle → bypass, same latency as ready dispatch.
- Fill all 16 entries with ops waiting on tag 15 → full=1; an extra dispatch is ignored. Broadcast tag 15 on cdb1 → results issue in dispatch order, one per cycle, rob tags matching dispatch sequence even after slot reuse out of index order.
- Hold res_ready=0 with 3 ready entries → res_valid/res_rob/res_val stable for 5 cycles, no entry freed. Release → remaining 2 drain in age order.
- Flush asserted with 4 entries busy, res_valid=1, and a concurrent disp_valid → next cycle full=0, res_valid=0, no results ever emitted for those ops.
- Ops SRA a=0x80000000 b=4 → 0xF8000000; SLTU a=1 b=0xFFFFFFFF → 1; JALR a=0x1001 imm=2 → 0x1002; rdy=0 for 3 cycles mid-stream → no output change.
